// File: rtl/display_scanner.sv
// Time-multiplexed N-digit 7-segment scanner.
// Walks the digits one prescaler tick at a time, with dead-time between digits.
// Each digit's segments come from a shadow word, which changes only at a frame start.
// A load request is parked in a pending register until digit 0 is about to light.
module display_scanner #(
    parameter int N_DIG          = 4,
    parameter int BLANK_TICKS    = 1,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Tick,
    input  logic [4*N_DIG-1:0] i_Data,
    input  logic [N_DIG-1:0]   i_Dp,
    input  logic               i_Lzb,
    input  logic               i_Load,
    output logic               o_Pending,
    output logic               o_Ack,
    output logic [6:0]         o_Seg,
    output logic               o_Dp,
    output logic [N_DIG-1:0]   o_An,
    output logic               o_Frame
);

    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [6:0]       SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic             DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [N_DIG-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    typedef enum logic {ST_BLANK, ST_SHOW} state_t;

    state_t               state_reg, state_next;
    logic [IDX_W-1:0]     idx_reg, idx_next;
    logic [3:0]           cnt_reg, cnt_next;
    logic [4*N_DIG-1:0]   shadow_data_reg, shadow_data_next;
    logic [N_DIG-1:0]     shadow_dp_reg, shadow_dp_next;
    logic [4*N_DIG-1:0]   pend_data_reg, pend_data_next;
    logic [N_DIG-1:0]     pend_dp_reg, pend_dp_next;
    logic                 pending_reg, pending_next;
    logic                 ack_reg, frame_reg, frame_next, dp_reg, dp_next;
    logic [6:0]           seg_reg, seg_next;
    logic [N_DIG-1:0]     an_reg, an_next, an_on;
    logic                 enter_show, commit;
    logic [3:0]           nib [N_DIG];
    logic [N_DIG-1:0]     blank_digit;
    logic [6:0]           seg_raw;

    // Active-high {g,f,e,d,c,b,a} hex font.
    function automatic logic [6:0] hex_font(input logic [3:0] v);
        case (v)
            4'h0: hex_font = 7'h3F;  4'h1: hex_font = 7'h06;
            4'h2: hex_font = 7'h5B;  4'h3: hex_font = 7'h4F;
            4'h4: hex_font = 7'h66;  4'h5: hex_font = 7'h6D;
            4'h6: hex_font = 7'h7D;  4'h7: hex_font = 7'h07;
            4'h8: hex_font = 7'h7F;  4'h9: hex_font = 7'h6F;
            4'hA: hex_font = 7'h77;  4'hB: hex_font = 7'h7C;
            4'hC: hex_font = 7'h39;  4'hD: hex_font = 7'h5E;
            4'hE: hex_font = 7'h79;  default: hex_font = 7'h71;
        endcase
    endfunction

    // State register: scan position and dead-time counter.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            state_reg <= ST_BLANK;
            idx_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: only a tick ever moves the scanner.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        enter_show = 1'b0;
        if (i_Tick) begin
            case (state_reg)
                ST_BLANK: begin
                    if (cnt_reg == 4'(BLANK_TICKS - 1)) begin
                        state_next = ST_SHOW;
                        cnt_next   = '0;
                        enter_show = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_next = ST_BLANK;
                    idx_next   = (idx_reg == IDX_W'(N_DIG - 1)) ? '0 : idx_reg + 1'b1;
                end
            endcase
        end
    end

    // Data path: pending capture and frame-boundary commit (a same-edge load wins).
    always_comb begin
        commit           = enter_show && (idx_reg == '0) && (pending_reg || i_Load);
        shadow_data_next = shadow_data_reg;
        shadow_dp_next   = shadow_dp_reg;
        pend_data_next   = pend_data_reg;
        pend_dp_next     = pend_dp_reg;
        pending_next     = pending_reg;
        if (commit) begin
            shadow_data_next = i_Load ? i_Data : pend_data_reg;
            shadow_dp_next   = i_Load ? i_Dp   : pend_dp_reg;
            pending_next     = 1'b0;
        end else if (i_Load) begin
            pend_data_next = i_Data;
            pend_dp_next   = i_Dp;
            pending_next   = 1'b1;
        end
    end

    // Per-digit nibble slices and leading-zero blanking flags (digit 0 is never blanked).
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
        assign nib[gi] = shadow_data_next[4*gi +: 4];
        if (gi == 0) begin : g_lsd
            assign blank_digit[gi] = 1'b0;
        end else begin : g_upper
            assign blank_digit[gi] = i_Lzb && (shadow_data_next[4*N_DIG-1:4*gi] == '0);
        end
    end

    // Output logic: light the new digit on entry to SHOW, go dark on leaving it.
    always_comb begin
        an_on      = '0;
        an_on[idx_reg] = 1'b1;
        seg_raw    = hex_font(nib[idx_reg]);
        an_next    = an_reg;
        seg_next   = seg_reg;
        dp_next    = dp_reg;
        frame_next = 1'b0;
        if (enter_show) begin
            frame_next = (idx_reg == '0);
            if (blank_digit[idx_reg]) begin
                an_next  = AN_OFF;
                seg_next = SEG_OFF;
                dp_next  = DP_OFF;
            end else begin
                an_next  = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
                seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
                dp_next  = (SEG_ACTIVE_LOW != 0) ? ~shadow_dp_next[idx_reg] : shadow_dp_next[idx_reg];
            end
        end else if (i_Tick && state_reg == ST_SHOW) begin
            an_next  = AN_OFF;
            seg_next = SEG_OFF;
            dp_next  = DP_OFF;
        end
    end

    // Registered data path and display outputs.
    always_ff @(posedge i_Clk) begin
        if (!i_Reset) begin
            shadow_data_reg <= '0;
            shadow_dp_reg   <= '0;
            pend_data_reg   <= '0;
            pend_dp_reg     <= '0;
            pending_reg     <= 1'b0;
            ack_reg         <= 1'b0;
            frame_reg       <= 1'b0;
            an_reg          <= AN_OFF;
            seg_reg         <= SEG_OFF;
            dp_reg          <= DP_OFF;
        end else begin
            shadow_data_reg <= shadow_data_next;
            shadow_dp_reg   <= shadow_dp_next;
            pend_data_reg   <= pend_data_next;
            pend_dp_reg     <= pend_dp_next;
            pending_reg     <= pending_next;
            ack_reg         <= commit;
            frame_reg       <= frame_next;
            an_reg          <= an_next;
            seg_reg         <= seg_next;
            dp_reg          <= dp_next;
        end
    end

    assign o_Pending = pending_reg;
    assign o_Ack     = ack_reg;
    assign o_Frame   = frame_reg;
    assign o_An      = an_reg;
    assign o_Seg     = seg_reg;
    assign o_Dp      = dp_reg;

endmodule

// File: tb/tb_display_scanner.sv
// Directed testbench for display_scanner (4 digits, one dead-time tick, active-low board).
module tb_display_scanner;

    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30, S4 = 7'h19;
    localparam logic [6:0] S5 = 7'h12, S6 = 7'h02, S7 = 7'h78, SA = 7'h08, OFF = 7'h7F;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic        i_Tick = 1'b0;
    logic [15:0] i_Data = '0;
    logic [3:0]  i_Dp = '0;
    logic        i_Lzb = 1'b0;
    logic        i_Load = 1'b0;
    logic        o_Pending, o_Ack, o_Dp, o_Frame;
    logic [6:0]  o_Seg;
    logic [3:0]  o_An;

    int checks = 0;
    int fails  = 0;

    display_scanner dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Tick(i_Tick), .i_Data(i_Data),
        .i_Dp(i_Dp), .i_Lzb(i_Lzb), .i_Load(i_Load), .o_Pending(o_Pending),
        .o_Ack(o_Ack), .o_Seg(o_Seg), .o_Dp(o_Dp), .o_An(o_An), .o_Frame(o_Frame)
    );

    always #5 i_Clk = ~i_Clk;

    // One-cycle tick; returns at the falling edge after the sampling edge.
    task automatic tick();
        @(negedge i_Clk) i_Tick = 1'b1;
        @(negedge i_Clk) i_Tick = 1'b0;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp);
        @(negedge i_Clk) begin i_Load = 1'b1; i_Data = d; i_Dp = dp; end
        @(negedge i_Clk) i_Load = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset = 1'b0;
        i_Load = 1'b1; i_Data = 16'h1234;
        repeat (5) tick();
        i_Load = 1'b0;
        checks++; if (o_An !== 4'b1111) begin fails++; $display("FAIL reset_an got %b want 1111", o_An); end
        checks++; if (o_Seg !== OFF) begin fails++; $display("FAIL reset_seg got %b want %b", o_Seg, OFF); end
        checks++; if (o_Dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", o_Dp); end
        checks++; if (o_Ack !== 1'b0 || o_Frame !== 1'b0) begin fails++; $display("FAIL reset_pulses got ack=%b frame=%b want 0 0", o_Ack, o_Frame); end
        checks++; if (o_Pending !== 1'b0) begin fails++; $display("FAIL reset_pending got %b want 0", o_Pending); end
        $display("test_reset: done");
        @(negedge i_Clk) i_Reset = 1'b1;
    endtask

    task automatic test_scan();
        logic [6:0] es [4];
        logic [3:0] dp, ea;
        es = '{S4, S3, S2, S1};
        dp = 4'b0101;
        load(16'h1234, dp);
        checks++; if (o_Pending !== 1'b1) begin fails++; $display("FAIL scan_pending got %b want 1", o_Pending); end
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 2) repeat (3) @(negedge i_Clk);
            ea = 4'b1111; ea[k] = 1'b0;
            checks++; if (o_An !== ea) begin fails++; $display("FAIL scan_an%0d got %b want %b", k, o_An, ea); end
            checks++; if (o_Seg !== es[k]) begin fails++; $display("FAIL scan_seg%0d got %b want %b", k, o_Seg, es[k]); end
            checks++; if (o_Dp !== ~dp[k]) begin fails++; $display("FAIL scan_dp%0d got %b want %b", k, o_Dp, ~dp[k]); end
            checks++; if (o_Ack !== (k == 0) || o_Frame !== (k == 0)) begin fails++; $display("FAIL scan_pulse%0d got ack=%b frame=%b want %0d", k, o_Ack, o_Frame, k == 0); end
            if (k == 0) begin
                checks++; if (o_Pending !== 1'b0) begin fails++; $display("FAIL scan_pend_clr got %b want 0", o_Pending); end
            end
            tick();
            checks++; if (o_An !== 4'b1111 || o_Seg !== OFF) begin fails++; $display("FAIL scan_blank%0d got an=%b seg=%b want 1111 %b", k, o_An, o_Seg, OFF); end
        end
        $display("test_scan: frame of 1234 scanned");
    endtask

    task automatic test_lzb();
        logic [6:0] es [4];
        logic [3:0] ea;
        i_Lzb = 1'b1;
        load(16'h0070, 4'b0000);
        for (int pass = 0; pass < 2; pass++) begin
            es = (pass == 0) ? '{S0, S7, OFF, OFF} : '{S0, S7, S0, S0};
            if (pass == 1) i_Lzb = 1'b0;
            for (int k = 0; k < 4; k++) begin
                tick();
                ea = 4'b1111;
                if (pass == 1 || k < 2) ea[k] = 1'b0;
                checks++; if (o_An !== ea) begin fails++; $display("FAIL lzb%0d_an%0d got %b want %b", pass, k, o_An, ea); end
                checks++; if (o_Seg !== es[k] || o_Dp !== 1'b1) begin fails++; $display("FAIL lzb%0d_seg%0d got %b dp=%b want %b dp=1", pass, k, o_Seg, o_Dp, es[k]); end
                tick();
            end
            $display("test_lzb: pass %0d frame done", pass);
        end
    endtask

    task automatic test_tearing();
        load(16'hAAAA, 4'b0000);
        tick();
        checks++; if (o_Ack !== 1'b1) begin fails++; $display("FAIL tear_ack_a got %b want 1", o_Ack); end
        repeat (4) tick();
        load(16'h5555, 4'b0000);
        checks++; if (o_Seg !== SA || o_An !== 4'b1011) begin fails++; $display("FAIL tear_d2 got seg=%b an=%b want %b 1011", o_Seg, o_An, SA); end
        checks++; if (o_Pending !== 1'b1) begin fails++; $display("FAIL tear_pending got %b want 1", o_Pending); end
        tick(); tick();
        checks++; if (o_Seg !== SA || o_An !== 4'b0111 || o_Ack !== 1'b0) begin fails++; $display("FAIL tear_d3 got seg=%b an=%b ack=%b want %b 0111 0", o_Seg, o_An, o_Ack, SA); end
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (o_Seg !== S5) begin fails++; $display("FAIL tear_new%0d got %b want %b", k, o_Seg, S5); end
            checks++; if (o_Ack !== (k == 0) || o_Frame !== (k == 0)) begin fails++; $display("FAIL tear_pulse%0d got ack=%b frame=%b want %0d", k, o_Ack, o_Frame, k == 0); end
            tick();
        end
        $display("test_tearing: old frame kept, 5555 committed at next frame");
    endtask

    task automatic test_back_to_back();
        load(16'h1111, 4'b0000);
        load(16'h2222, 4'b0000);
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 4; k++) begin
                tick();
                checks++; if (o_Seg !== S2) begin fails++; $display("FAIL b2b_f%0d_seg%0d got %b want %b", f, k, o_Seg, S2); end
                checks++; if (o_Ack !== (f == 0 && k == 0)) begin fails++; $display("FAIL b2b_f%0d_ack%0d got %b want %0d", f, k, o_Ack, f == 0 && k == 0); end
                tick();
            end
        end
        load(16'h4444, 4'b0000);
        @(negedge i_Clk) begin i_Tick = 1'b1; i_Load = 1'b1; i_Data = 16'h6666; end
        @(negedge i_Clk) begin i_Tick = 1'b0; i_Load = 1'b0; end
        checks++; if (o_Seg !== S6 || o_Ack !== 1'b1) begin fails++; $display("FAIL b2b_newest got seg=%b ack=%b want %b 1", o_Seg, o_Ack, S6); end
        checks++; if (o_Pending !== 1'b0) begin fails++; $display("FAIL b2b_pend got %b want 0", o_Pending); end
        @(negedge i_Clk);
        checks++; if (o_Ack !== 1'b0) begin fails++; $display("FAIL b2b_ack_len got %b want 0", o_Ack); end
        repeat (7) tick();
        $display("test_back_to_back: last load wins, single ack");
    endtask

    task automatic test_reset_mid();
        repeat (5) tick();
        load(16'h8888, 4'b1111);
        checks++; if (o_An !== 4'b1011 || o_Pending !== 1'b1) begin fails++; $display("FAIL rst_pre got an=%b pend=%b want 1011 1", o_An, o_Pending); end
        @(negedge i_Clk) i_Reset = 1'b0;
        @(negedge i_Clk) i_Reset = 1'b1;
        checks++; if (o_An !== 4'b1111 || o_Seg !== OFF || o_Dp !== 1'b1) begin fails++; $display("FAIL rst_off got an=%b seg=%b dp=%b want 1111 %b 1", o_An, o_Seg, o_Dp, OFF); end
        checks++; if (o_Pending !== 1'b0 || o_Ack !== 1'b0) begin fails++; $display("FAIL rst_pend got pend=%b ack=%b want 0 0", o_Pending, o_Ack); end
        tick();
        checks++; if (o_An !== 4'b1110 || o_Seg !== S0) begin fails++; $display("FAIL rst_first got an=%b seg=%b want 1110 %b", o_An, o_Seg, S0); end
        checks++; if (o_Ack !== 1'b0 || o_Frame !== 1'b1) begin fails++; $display("FAIL rst_pulses got ack=%b frame=%b want 0 1", o_Ack, o_Frame); end
        $display("test_reset_mid: restarted at digit 0");
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lzb();
        test_tearing();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
